// File: rtl/usb_rx_delay_buf.sv
// USB receive delay buffer: withholds the trailing DEPTH words (CRC) of a packet and
// releases older words as payload. Optional byte counter: define USB_RX_DELAY_BUF_BYTE_CNT_EN.
module usb_rx_delay_buf #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 2,
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      load_buf,
   input  logic                      flush,
   input  logic                      eop,
   input  logic [DATA_W-1:0]         p_out,
   output logic [DATA_W-1:0]         rcv_data,
   output logic                      rcv_valid,
   output logic [CNT_W-1:0]          fill_cnt,
   output logic [DEPTH*DATA_W-1:0]   tail_data,
   output logic [CNT_W-1:0]          tail_len,
   output logic                      tail_valid
`ifdef USB_RX_DELAY_BUF_BYTE_CNT_EN
   ,
   output logic [15:0]               byte_cnt
`endif
);

   logic [DATA_W-1:0]       stage_q [DEPTH];
   logic [DATA_W-1:0]       stage_d [DEPTH];
   logic [CNT_W-1:0]        fill_q, fill_d;
   logic [DATA_W-1:0]       rcv_data_q, rcv_data_d;
   logic                    rcv_valid_q, rcv_valid_d;
   logic [DEPTH*DATA_W-1:0] tail_data_q, tail_data_d;
   logic [CNT_W-1:0]        tail_len_q, tail_len_d;
   logic                    tail_valid_q, tail_valid_d;
   logic                    full;

   assign full = (fill_q == CNT_W'(DEPTH));

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      stage_d      = stage_q;
      fill_d       = fill_q;
      rcv_data_d   = rcv_data_q;
      rcv_valid_d  = 1'b0;
      tail_data_d  = tail_data_q;
      tail_len_d   = tail_len_q;
      tail_valid_d = 1'b0;

      if (flush) begin
         for (int i = 0; i < DEPTH; i++) stage_d[i] = '0;
         fill_d      = '0;
         rcv_data_d  = '0;
         tail_data_d = '0;
         tail_len_d  = '0;
      end else begin
         if (load_buf) begin
            if (full) begin
               rcv_data_d  = stage_q[DEPTH-1];
               rcv_valid_d = 1'b1;
            end else begin
               fill_d = fill_q + CNT_W'(1);
            end
            for (int i = DEPTH - 1; i > 0; i--) stage_d[i] = stage_q[i-1];
            stage_d[0] = p_out;
         end
         // Tail sees the post-load chain; stage i lands in slice i so the newest word is at the LSB.
         if (eop) begin
            tail_data_d = '0;
            for (int i = 0; i < DEPTH; i++) begin
               if (CNT_W'(i) < fill_d) tail_data_d[i*DATA_W +: DATA_W] = stage_d[i];
            end
            tail_len_d   = fill_d;
            tail_valid_d = 1'b1;
            for (int i = 0; i < DEPTH; i++) stage_d[i] = '0;
            fill_d = '0;
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   // NOTE: the stage array is small and must read as zero in reset, so it is reset like any flop.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
         fill_q       <= '0;
         rcv_data_q   <= '0;
         rcv_valid_q  <= 1'b0;
         tail_data_q  <= '0;
         tail_len_q   <= '0;
         tail_valid_q <= 1'b0;
      end else begin
         stage_q      <= stage_d;
         fill_q       <= fill_d;
         rcv_data_q   <= rcv_data_d;
         rcv_valid_q  <= rcv_valid_d;
         tail_data_q  <= tail_data_d;
         tail_len_q   <= tail_len_d;
         tail_valid_q <= tail_valid_d;
      end
   end

   assign rcv_data   = rcv_data_q;
   assign rcv_valid  = rcv_valid_q;
   assign fill_cnt   = fill_q;
   assign tail_data  = tail_data_q;
   assign tail_len   = tail_len_q;
   assign tail_valid = tail_valid_q;

`ifdef USB_RX_DELAY_BUF_BYTE_CNT_EN
   logic [15:0] byte_cnt_q, byte_cnt_d;

   // Packet boundaries clear the count even when the same edge also releases a word.
   always_comb begin
      byte_cnt_d = byte_cnt_q;
      if (flush || eop) begin
         byte_cnt_d = '0;
      end else if (rcv_valid_d && (byte_cnt_q != 16'hFFFF)) begin
         byte_cnt_d = byte_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) byte_cnt_q <= '0;
      else     byte_cnt_q <= byte_cnt_d;
   end

   assign byte_cnt = byte_cnt_q;
`endif

endmodule

// File: tb/tb_usb_rx_delay_buf.sv
// Testbench for usb_rx_delay_buf: DEPTH=2/DATA_W=8 and DEPTH=4/DATA_W=16 instances
// checked against a word-list reference model with directed and random stimulus.
module tb_usb_rx_delay_buf;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        ld [2];
   logic        fl [2];
   logic        ep [2];
   logic [15:0] pd [2];

   logic [7:0]  rcv_data_a;
   logic        rcv_valid_a;
   logic [1:0]  fill_cnt_a;
   logic [15:0] tail_data_a;
   logic [1:0]  tail_len_a;
   logic        tail_valid_a;

   logic [15:0] rcv_data_b;
   logic        rcv_valid_b;
   logic [2:0]  fill_cnt_b;
   logic [63:0] tail_data_b;
   logic [2:0]  tail_len_b;
   logic        tail_valid_b;

`ifdef USB_RX_DELAY_BUF_BYTE_CNT_EN
   logic [15:0] byte_cnt_a, byte_cnt_b;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   usb_rx_delay_buf #(.DATA_W(8), .DEPTH(2)) dut_a (
      .clk(clk), .rst(rst), .load_buf(ld[0]), .flush(fl[0]), .eop(ep[0]), .p_out(pd[0][7:0]),
      .rcv_data(rcv_data_a), .rcv_valid(rcv_valid_a), .fill_cnt(fill_cnt_a),
      .tail_data(tail_data_a), .tail_len(tail_len_a), .tail_valid(tail_valid_a)
`ifdef USB_RX_DELAY_BUF_BYTE_CNT_EN
      , .byte_cnt(byte_cnt_a)
`endif
   );

   usb_rx_delay_buf #(.DATA_W(16), .DEPTH(4)) dut_b (
      .clk(clk), .rst(rst), .load_buf(ld[1]), .flush(fl[1]), .eop(ep[1]), .p_out(pd[1]),
      .rcv_data(rcv_data_b), .rcv_valid(rcv_valid_b), .fill_cnt(fill_cnt_b),
      .tail_data(tail_data_b), .tail_len(tail_len_b), .tail_valid(tail_valid_b)
`ifdef USB_RX_DELAY_BUF_BYTE_CNT_EN
      , .byte_cnt(byte_cnt_b)
`endif
   );

   // Reference model: held words kept in arrival order, index 0 is the oldest.
   logic [15:0] m_w  [2][8];
   int          m_n  [2];
   logic [15:0] m_rd [2];
   bit          m_rv [2];
   logic [63:0] m_td [2];
   int          m_tl [2];
   bit          m_tv [2];
   int          m_bc [2];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_n[k] = 0; m_rd[k] = '0; m_rv[k] = 0; m_td[k] = '0;
         m_tl[k] = 0; m_tv[k] = 0; m_bc[k] = 0;
         for (int i = 0; i < 8; i++) m_w[k][i] = '0;
      end
   endtask

   task automatic model_step(input int k);
      int          depth;
      int          w;
      logic [15:0] mask;
      depth = (k == 0) ? 2 : 4;
      w     = (k == 0) ? 8 : 16;
      mask  = (k == 0) ? 16'h00FF : 16'hFFFF;
      m_rv[k] = 0;
      m_tv[k] = 0;
      if (fl[k]) begin
         m_n[k] = 0; m_rd[k] = '0; m_td[k] = '0; m_tl[k] = 0; m_bc[k] = 0;
      end else begin
         if (ld[k]) begin
            if (m_n[k] == depth) begin
               m_rd[k] = m_w[k][0];
               m_rv[k] = 1;
               for (int i = 0; i < depth - 1; i++) m_w[k][i] = m_w[k][i+1];
               m_n[k]--;
               if (m_bc[k] != 16'hFFFF) m_bc[k]++;
            end
            m_w[k][m_n[k]] = pd[k] & mask;
            m_n[k]++;
         end
         if (ep[k]) begin
            m_td[k] = '0;
            for (int i = 0; i < m_n[k]; i++)
               m_td[k] = m_td[k] | (64'(m_w[k][m_n[k]-1-i]) << (i * w));
            m_tl[k] = m_n[k];
            m_tv[k] = 1;
            m_n[k]  = 0;
            m_bc[k] = 0;
         end
      end
   endtask

   task automatic check_all();
      check("a.rcv_valid",  64'(rcv_valid_a),  64'(m_rv[0]));
      check("a.rcv_data",   64'(rcv_data_a),   64'(m_rd[0]));
      check("a.fill_cnt",   64'(fill_cnt_a),   64'(m_n[0]));
      check("a.tail_valid", 64'(tail_valid_a), 64'(m_tv[0]));
      check("a.tail_data",  64'(tail_data_a),  m_td[0]);
      check("a.tail_len",   64'(tail_len_a),   64'(m_tl[0]));
      check("b.rcv_valid",  64'(rcv_valid_b),  64'(m_rv[1]));
      check("b.rcv_data",   64'(rcv_data_b),   64'(m_rd[1]));
      check("b.fill_cnt",   64'(fill_cnt_b),   64'(m_n[1]));
      check("b.tail_valid", 64'(tail_valid_b), 64'(m_tv[1]));
      check("b.tail_data",  tail_data_b,       m_td[1]);
      check("b.tail_len",   64'(tail_len_b),   64'(m_tl[1]));
`ifdef USB_RX_DELAY_BUF_BYTE_CNT_EN
      check("a.byte_cnt",   64'(byte_cnt_a),   64'(m_bc[0]));
      check("b.byte_cnt",   64'(byte_cnt_b),   64'(m_bc[1]));
`endif
   endtask

   task automatic clear_inputs();
      for (int k = 0; k < 2; k++) begin
         ld[k] = 1'b0; fl[k] = 1'b0; ep[k] = 1'b0; pd[k] = '0;
      end
   endtask

   // Inputs are set #1 after a rising edge, so the next edge samples them cleanly.
   task automatic cycle();
      @(posedge clk);
      #1;
      for (int k = 0; k < 2; k++) model_step(k);
      check_all();
   endtask

   task automatic tick(input int k, input bit l, input bit e, input bit f, input logic [15:0] d);
      clear_inputs();
      ld[k] = l; ep[k] = e; fl[k] = f; pd[k] = d;
      cycle();
      clear_inputs();
   endtask

   initial begin
      int releases;
      clear_inputs();
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_all();
      rst = 1'b0;

      // Four loads on the DEPTH=2 instance: A1 and A2 come out, A3/A4 stay held.
      tick(0, 1, 0, 0, 16'h00A1);
      check("a.fill after A1", 64'(fill_cnt_a), 64'd1);
      tick(0, 1, 0, 0, 16'h00A2);
      tick(0, 1, 0, 0, 16'h00A3);
      check("a.release A1", 64'(rcv_data_a), 64'hA1);
      tick(0, 1, 0, 0, 16'h00A4);
      check("a.release A2", 64'(rcv_data_a), 64'hA2);
      check("a.fill full", 64'(fill_cnt_a), 64'd2);
      tick(0, 0, 0, 0, 16'h0000);
      check("a.rcv_valid idle", 64'(rcv_valid_a), 64'd0);
      tick(0, 0, 1, 0, 16'h0000);
      check("a.tail A3A4", 64'(tail_data_a), 64'hA3A4);
      check("a.tail_len 2", 64'(tail_len_a), 64'd2);

      // Single word packet, then an empty eop.
      tick(0, 1, 0, 0, 16'h0055);
      tick(0, 0, 1, 0, 16'h0000);
      check("a.tail 0055", 64'(tail_data_a), 64'h0055);
      tick(0, 0, 1, 0, 16'h0000);
      check("a.empty tail_len", 64'(tail_len_a), 64'd0);
      check("a.empty tail_valid", 64'(tail_valid_a), 64'd1);

      // Load coinciding with eop on a full chain.
      tick(0, 1, 0, 0, 16'h0011);
      tick(0, 1, 0, 0, 16'h0022);
      tick(0, 1, 1, 0, 16'h0033);
      check("a.eop+load release", 64'(rcv_data_a), 64'h11);
      check("a.tail 2233", 64'(tail_data_a), 64'h2233);

      // Flush beats load and eop.
      tick(0, 1, 0, 0, 16'h0077);
      tick(0, 1, 1, 1, 16'h0088);
      check("a.flush tail_valid", 64'(tail_valid_a), 64'd0);
      check("a.flush rcv_data", 64'(rcv_data_a), 64'd0);

      // Asynchronous reset mid-packet: zeros appear without a clock edge.
      tick(0, 1, 0, 0, 16'h0091);
      tick(0, 1, 0, 0, 16'h0092);
      check("a.fill before rst", 64'(fill_cnt_a), 64'd2);
      #2 rst = 1'b1;
      #1;
      model_reset();
      check_all();
      @(posedge clk);
      #1 rst = 1'b0;
      tick(0, 1, 0, 0, 16'h00C0);
      check("a.fill after rst", 64'(fill_cnt_a), 64'd1);
      tick(0, 1, 0, 1, 16'h0000);

      // DEPTH=4, DATA_W=16: ten loads release six words.
      releases = 0;
      for (int i = 0; i < 10; i++) begin
         tick(1, 1, 0, 0, 16'h1000 + 16'(i));
         if (rcv_valid_b) releases++;
      end
      check("b.release count", 64'(releases), 64'd6);
`ifdef USB_RX_DELAY_BUF_BYTE_CNT_EN
      check("b.byte_cnt 6", 64'(byte_cnt_b), 64'd6);
`endif
      tick(1, 0, 1, 0, 16'h0000);
      check("b.tail_len 4", 64'(tail_len_b), 64'd4);
      check("b.tail 1006..1009", tail_data_b, 64'h1006_1007_1008_1009);
`ifdef USB_RX_DELAY_BUF_BYTE_CNT_EN
      check("b.byte_cnt clear", 64'(byte_cnt_b), 64'd0);
`endif

      // Random traffic on both instances together.
      for (int n = 0; n < 500; n++) begin
         for (int k = 0; k < 2; k++) begin
            ld[k] = ($urandom_range(0, 9) < 6);
            ep[k] = ($urandom_range(0, 15) == 0);
            fl[k] = ($urandom_range(0, 39) == 0);
            pd[k] = 16'($urandom);
         end
         cycle();
      end
      clear_inputs();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
